// File: rtl/dmem_req_unit_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory request unit.
// Holds the access-size and FSM state enums plus the byte-lane arithmetic
// that both the request path and the load aligner rely on.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Size code 3 has no meaning of its own and behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return SZ_B;
            2'd1:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // Byte offset inside the word actually used by an access; address bits
    // finer than the access size are dropped.
    function automatic logic [1:0] lane_offset(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    // Store data is replicated across the word so every possible lane
    // already carries the right bytes; the strobe picks the live ones.
    function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_req_unit_if.sv
// Valid/ready data-memory bus between the request unit (master) and the
// memory responder (slave). Writes are posted; reads return on m_rvalid.
interface dmem_req_unit_if #(
    parameter int AW = 32
);
    logic          m_valid;
    logic          m_ready;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_rvalid;
    logic [31:0]   m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/dmem_req_unit_load_align.sv
// Load data aligner: moves the addressed bytes of a read word down to bit 0
// and sign- or zero-extends them according to the access size.
import dmem_pkg::*;

module dmem_load_align (
    input  logic [31:0] rdata,
    input  size_e       size,
    input  logic        uns,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the selected lane down, then extend to the full register width.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SZ_B:    data = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_req_unit.sv
// MEM-stage data-memory initiator. Converts pipeline load/store controls into
// a valid/ready request, waits for read data, and stalls the pipeline while
// an access is in flight. A watchdog (TO_CYCLES, 0 = off) turns a hung access
// into a one-cycle bus_err pulse.
// Optional build macro DMEM_MISALIGN_EXC_EN: misaligned half/word accesses
// skip the bus entirely and pulse the extra misalign output instead.
import dmem_pkg::*;

module dmem_req_unit #(
    parameter int AW        = 32,
    parameter int TO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Mem_Alu_R,
    input  logic [31:0] Mem_D2,
    input  logic        Mem_Rmem,
    input  logic        Mem_Wmem,
    input  logic [1:0]  Mem_Size,
    input  logic        Mem_Uns,
    output logic        stall,
    output logic [31:0] Dout,
    output logic        ld_done,
    output logic        bus_err,
`ifdef DMEM_MISALIGN_EXC_EN
    output logic        misalign,
`endif
    dmem_req_unit_if.master mem
);

    // Wide enough to hold TO_CYCLES itself, since a load handshake on the
    // last REQ cycle carries the count one past the limit into RSP.
    localparam int CW = $clog2(TO_CYCLES + 2);

    state_e        state;
    size_e         lat_size;
    logic          lat_uns;
    logic          lat_we;
    logic [1:0]    lat_off;
    logic [CW-1:0] wd_cnt;
    logic          wd_expired;
    size_e         req_size;
    logic          req_misaligned;
    logic [31:0]   aligned;

    assign req_size = decode_size(Mem_Size);

`ifdef DMEM_MISALIGN_EXC_EN
    assign req_misaligned = is_misaligned(req_size, Mem_Alu_R[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // The count equals the number of REQ/RSP cycles already spent; the
    // handshake or response still wins on the final cycle.
    assign wd_expired = (TO_CYCLES != 0) && (wd_cnt >= CW'(TO_CYCLES - 1));

    // The pipeline must freeze in the very cycle a new access shows up.
    assign stall = (state == ST_REQ) || (state == ST_RSP) ||
                   ((state == ST_IDLE) && (Mem_Rmem || Mem_Wmem));

    dmem_load_align u_align (
        .rdata  (mem.m_rdata),
        .size   (lat_size),
        .uns    (lat_uns),
        .offset (lat_off),
        .data   (aligned)
    );

    // Access sequencer: issue, handshake, collect read data, report, return.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            lat_size    <= SZ_B;
            lat_uns     <= 1'b0;
            lat_we      <= 1'b0;
            lat_off     <= 2'b00;
            wd_cnt      <= '0;
            Dout        <= 32'h0;
            ld_done     <= 1'b0;
            bus_err     <= 1'b0;
            mem.m_valid <= 1'b0;
            mem.m_we    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= 32'h0;
            mem.m_wstrb <= 4'h0;
`ifdef DMEM_MISALIGN_EXC_EN
            misalign    <= 1'b0;
`endif
        end else begin
            ld_done <= 1'b0;
            bus_err <= 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
            misalign <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (Mem_Rmem || Mem_Wmem) begin
                        lat_size <= req_size;
                        lat_uns  <= Mem_Uns;
                        lat_we   <= Mem_Wmem;
                        lat_off  <= lane_offset(req_size, Mem_Alu_R[1:0]);
                        if (req_misaligned) begin
                            Dout  <= 32'h0;
                            state <= ST_DONE;
`ifdef DMEM_MISALIGN_EXC_EN
                            misalign <= 1'b1;
`endif
                        end else begin
                            mem.m_valid <= 1'b1;
                            mem.m_we    <= Mem_Wmem;
                            mem.m_addr  <= {Mem_Alu_R[AW-1:2], 2'b00};
                            mem.m_wdata <= Mem_Wmem ? lane_wdata(req_size, Mem_D2) : 32'h0;
                            mem.m_wstrb <= Mem_Wmem ? lane_strobe(req_size, Mem_Alu_R[1:0]) : 4'h0;
                            wd_cnt      <= '0;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (TO_CYCLES != 0) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                    if (mem.m_ready) begin
                        mem.m_valid <= 1'b0;
                        state       <= lat_we ? ST_DONE : ST_RSP;
                    end else if (wd_expired) begin
                        mem.m_valid <= 1'b0;
                        bus_err     <= 1'b1;
                        Dout        <= 32'h0;
                        state       <= ST_DONE;
                    end
                end
                ST_RSP: begin
                    if (TO_CYCLES != 0) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                    if (mem.m_rvalid) begin
                        Dout    <= aligned;
                        ld_done <= 1'b1;
                        state   <= ST_DONE;
                    end else if (wd_expired) begin
                        bus_err <= 1'b1;
                        Dout    <= 32'h0;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_unit.sv
// Self-checking bench for dmem_req_unit: directed scenarios followed by
// randomized accesses, all checked against a byte-addressed memory model.
module tb_dmem_req_unit;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] mem_alu_r;
    logic [31:0] mem_d2;
    logic        mem_rmem;
    logic        mem_wmem;
    logic [1:0]  mem_size;
    logic        mem_uns;
    logic        stall;
    logic [31:0] dout;
    logic        ld_done;
    logic        bus_err;
`ifdef DMEM_MISALIGN_EXC_EN
    logic        misalign;
`endif

    logic [7:0] mem_bytes [0:63];
    int tests_run    = 0;
    int tests_failed = 0;

    dmem_req_unit_if #(.AW(32)) mem_bus ();

    dmem_req_unit #(.AW(32), .TO_CYCLES(TO)) dut (
        .clk       (clk),
        .clr       (clr),
        .Mem_Alu_R (mem_alu_r),
        .Mem_D2    (mem_d2),
        .Mem_Rmem  (mem_rmem),
        .Mem_Wmem  (mem_wmem),
        .Mem_Size  (mem_size),
        .Mem_Uns   (mem_uns),
        .stall     (stall),
        .Dout      (dout),
        .ld_done   (ld_done),
        .bus_err   (bus_err),
`ifdef DMEM_MISALIGN_EXC_EN
        .misalign  (misalign),
`endif
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input int sz);
        if (sz == 0) return 1;
        if (sz == 1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input int ea, input int n, input bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_bytes[ea + i];
        if (!uns && n < 4 && v[8*n - 1]) begin
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strobe(input int ea, input int n);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < n; i++) s[(ea + i) % 4] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d2, input int n);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = d2[8*(j % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_word(input int wa);
        return {mem_bytes[wa + 3], mem_bytes[wa + 2], mem_bytes[wa + 1], mem_bytes[wa]};
    endfunction

    function automatic bit model_misaligned(input int addr, input int n);
`ifdef DMEM_MISALIGN_EXC_EN
        return (addr % n) != 0;
`else
        return (addr % n) != 0 && 1'b0;
`endif
    endfunction

    // One complete access, checked every cycle from the request cycle (c=0)
    // until one idle cycle after DONE. rdy_dly/rv_dly are the memory waits.
    task automatic applyStimulus(input bit we, input int addr, input logic [31:0] d2,
                                 input int sz, input bit uns, input int rdy_dly, input int rv_dly,
                                 output logic [31:0] obs_dout, output logic [3:0] obs_strb,
                                 output logic [31:0] obs_wdata);
        int n, ea, wa, hs_c, rv_c, done_c, valid_last, t;
        bit mis, timed_out, exp_valid;
        logic [31:0] exp_dout;
        n = size_bytes(sz);
        ea = addr - (addr % n);
        wa = ea - (ea % 4);
        mis = model_misaligned(addr, n);
        hs_c = 1 + rdy_dly;
        rv_c = hs_c + 1 + rv_dly;
        timed_out = 1'b0;
        if (mis) begin
            done_c = 1; valid_last = 0;
        end else if (hs_c > TO) begin
            timed_out = 1'b1; done_c = TO + 1; valid_last = TO;
        end else if (we) begin
            done_c = hs_c + 1; valid_last = hs_c;
        end else begin
            valid_last = hs_c;
            t = (hs_c + 1 > TO) ? hs_c + 1 : TO;
            if (rv_c <= t) done_c = rv_c + 1;
            else begin timed_out = 1'b1; done_c = t + 1; end
        end
        exp_dout = (timed_out || mis) ? 32'h0 : model_load(ea, n, uns);
        obs_dout = 32'h0; obs_strb = 4'h0; obs_wdata = 32'h0;

        mem_alu_r = addr;
        mem_d2    = d2;
        mem_wmem  = we;
        mem_rmem  = we ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_size  = 2'(sz);
        mem_uns   = uns;
        for (int c = 0; c <= done_c + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (c == done_c) begin mem_rmem = 1'b0; mem_wmem = 1'b0; end
            mem_bus.m_ready  = (!mis && c == hs_c);
            mem_bus.m_rvalid = (!mis && !we && c == rv_c);
            mem_bus.m_rdata  = mem_bus.m_rvalid ? model_word(wa) : $urandom;
            #1;
            exp_valid = !mis && c >= 1 && c <= valid_last;
            checkOutput("stall", stall, c < done_c);
            checkOutput("m_valid", mem_bus.m_valid, exp_valid);
            if (exp_valid) begin
                checkOutput("m_addr", mem_bus.m_addr, wa);
                checkOutput("m_we", mem_bus.m_we, we);
                checkOutput("m_wstrb", mem_bus.m_wstrb, we ? model_strobe(ea, n) : 4'h0);
                if (we) checkOutput("m_wdata", mem_bus.m_wdata, model_wdata(d2, n));
                obs_strb  = mem_bus.m_wstrb;
                obs_wdata = mem_bus.m_wdata;
            end
            checkOutput("ld_done", ld_done, c == done_c && !we && !timed_out && !mis);
            checkOutput("bus_err", bus_err, c == done_c && timed_out);
`ifdef DMEM_MISALIGN_EXC_EN
            checkOutput("misalign", misalign, c == done_c && mis);
`endif
            if (c == done_c && (!we || timed_out || mis)) begin
                checkOutput("dout", dout, exp_dout);
                obs_dout = dout;
            end
        end
        mem_bus.m_ready  = 1'b0;
        mem_bus.m_rvalid = 1'b0;
        if (we && !mis && !timed_out) begin
            for (int i = 0; i < n; i++) mem_bytes[ea + i] = d2[8*i +: 8];
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] stopped");
    end

    initial begin
        logic [31:0] o_dout, o_wdata;
        logic [3:0]  o_strb;
        for (int i = 0; i < 64; i++) mem_bytes[i] = 8'($urandom);
        clr = 1'b1;
        mem_alu_r = 32'h0; mem_d2 = 32'h0; mem_rmem = 1'b0; mem_wmem = 1'b0;
        mem_size = 2'd0; mem_uns = 1'b0;
        mem_bus.m_ready = 1'b0; mem_bus.m_rvalid = 1'b0; mem_bus.m_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_m_valid", mem_bus.m_valid, 1'b0);
        checkOutput("rst_m_we", mem_bus.m_we, 1'b0);
        checkOutput("rst_m_addr", mem_bus.m_addr, 32'h0);
        checkOutput("rst_m_wdata", mem_bus.m_wdata, 32'h0);
        checkOutput("rst_m_wstrb", mem_bus.m_wstrb, 4'h0);
        checkOutput("rst_dout", dout, 32'h0);
        checkOutput("rst_ld_done", ld_done, 1'b0);
        checkOutput("rst_bus_err", bus_err, 1'b0);
        clr = 1'b0;

        // Word store, immediate ready
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0, 0, 0, o_dout, o_strb, o_wdata);
        checkOutput("word_store_strb", o_strb, 4'hF);
        checkOutput("word_store_wdata", o_wdata, 32'hDEADBEEF);

        // Byte loads from lane 3, signed then unsigned
        mem_bytes[8'h13] = 8'h80;
        applyStimulus(1'b0, 32'h13, 32'h0, 0, 1'b0, 0, 0, o_dout, o_strb, o_wdata);
        checkOutput("byte_load_sext", o_dout, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h13, 32'h0, 0, 1'b1, 0, 0, o_dout, o_strb, o_wdata);
        checkOutput("byte_load_zext", o_dout, 32'h00000080);

        // Half store on the upper half-word
        applyStimulus(1'b1, 32'h06, 32'h1234ABCD, 1, 1'b0, 0, 0, o_dout, o_strb, o_wdata);
        checkOutput("half_store_strb", o_strb, 4'b1100);
        checkOutput("half_store_wdata", o_wdata, 32'hABCDABCD);

        // Slow memory: ready after 5 cycles, data 3 cycles later
        applyStimulus(1'b0, 32'h24, 32'h0, 2, 1'b0, 5, 3, o_dout, o_strb, o_wdata);

        // Watchdog: store never accepted, then load never answered
        applyStimulus(1'b1, 32'h08, 32'h55AA55AA, 2, 1'b0, 1000, 0, o_dout, o_strb, o_wdata);
        applyStimulus(1'b0, 32'h0C, 32'h0, 2, 1'b0, 0, 1000, o_dout, o_strb, o_wdata);

        // Reset while waiting for read data, followed by a late response
        mem_alu_r = 32'h20; mem_size = 2'd2; mem_rmem = 1'b1; mem_wmem = 1'b0;
        @(negedge clk);
        mem_bus.m_ready = 1'b1;
        @(negedge clk);
        mem_bus.m_ready = 1'b0;
        clr = 1'b1; mem_rmem = 1'b0;
        #1;
        checkOutput("clr_rsp_stall", stall, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        mem_bus.m_rvalid = 1'b1; mem_bus.m_rdata = 32'hCAFEF00D;
        #1;
        checkOutput("clr_stall", stall, 1'b0);
        checkOutput("clr_m_valid", mem_bus.m_valid, 1'b0);
        checkOutput("clr_dout", dout, 32'h0);
        @(negedge clk);
        mem_bus.m_rvalid = 1'b0;
        #1;
        checkOutput("late_rvalid_ld_done", ld_done, 1'b0);
        checkOutput("late_rvalid_stall", stall, 1'b0);
        @(negedge clk);
        checkOutput("late_rvalid_ld_done2", ld_done, 1'b0);
        checkOutput("late_rvalid_dout", dout, 32'h0);

`ifdef DMEM_MISALIGN_EXC_EN
        // Misaligned word load never reaches the bus
        applyStimulus(1'b0, 32'h02, 32'h0, 2, 1'b0, 0, 0, o_dout, o_strb, o_wdata);
        checkOutput("misalign_dout", o_dout, 32'h0);
`endif

        // Randomized mix of sizes, addresses, directions and wait states
        for (int k = 0; k < 150; k++) begin
            int rd, rv;
            rd = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(0, 3);
            rv = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, rv,
                          o_dout, o_strb, o_wdata);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
